// File: rtl/camera_ray_generator.sv
// rtl/camera_ray_generator.sv - per-pixel primary ray generator walking the raster in row-major order

package camera_ray_pkg;
   // Q16.16 signed fixed point
   typedef logic signed [31:0] fp_t;

   typedef struct packed {
      fp_t x;
      fp_t y;
      fp_t z;
   } vec3_t;

   localparam fp_t FP_ZERO = 32'sh0000_0000;
   localparam fp_t FP_ONE  = 32'sh0001_0000;
   localparam fp_t FP_MAX  = 32'sh7FFF_FFFF;
   localparam fp_t FP_MIN  = 32'sh8000_0000;

   // saturating add
   function automatic fp_t fp_add(input fp_t a, input fp_t b);
      logic [32:0] s;
      s = {a[31], a} + {b[31], b};
      if (s[32] != s[31]) return s[32] ? FP_MIN : FP_MAX;
      return fp_t'(s[31:0]);
   endfunction

   // saturating subtract
   function automatic fp_t fp_sub(input fp_t a, input fp_t b);
      logic [32:0] s;
      s = {a[31], a} - {b[31], b};
      if (s[32] != s[31]) return s[32] ? FP_MIN : FP_MAX;
      return fp_t'(s[31:0]);
   endfunction

   // saturating multiply, result truncated toward minus infinity
   function automatic fp_t fp_mul(input fp_t a, input fp_t b);
      logic signed [63:0] p;
      logic signed [63:0] sh;
      p  = 64'(a) * 64'(b);
      sh = p >>> 16;
      if (sh > 64'sh0000_0000_7FFF_FFFF) return FP_MAX;
      if (sh < 64'shFFFF_FFFF_8000_0000) return FP_MIN;
      return fp_t'(sh[31:0]);
   endfunction
endpackage

module camera_ray_generator
   import camera_ray_pkg::*;
#(
   parameter int  DISPLAY_WIDTH  = 320,
   parameter int  DISPLAY_HEIGHT = 240,
   parameter int  H_BITS         = 9,
   parameter int  V_BITS         = 8,
   parameter int  ADDR_BITS      = 17,
   parameter fp_t PIXEL_STEP     = fp_t'((2 * 65536) / DISPLAY_WIDTH)
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 start_in,
   input  vec3_t                pos_in,
   input  vec3_t                dir_in,
   output logic                 ray_valid_out,
   input  logic                 ray_ready_in,
   output vec3_t                ray_origin_out,
   output vec3_t                ray_dir_out,
   output logic [ADDR_BITS-1:0] ray_addr_out,
   output logic [H_BITS-1:0]    hcount_out,
   output logic [V_BITS-1:0]    vcount_out,
   output logic                 busy_out,
   output logic                 frame_done_out
);

   localparam fp_t U_START = fp_t'(-(DISPLAY_WIDTH / 2) * PIXEL_STEP);
   localparam fp_t V_START = fp_t'((DISPLAY_HEIGHT / 2) * PIXEL_STEP);
   localparam logic [H_BITS-1:0] H_LAST = H_BITS'(DISPLAY_WIDTH - 1);
   localparam logic [V_BITS-1:0] V_LAST = V_BITS'(DISPLAY_HEIGHT - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_t;

   state_t state_q, state_d;
   vec3_t  cam_pos_q, cam_pos_d;
   vec3_t  cam_fwd_q, cam_fwd_d;
   // u/v/h/vc/addr describe the next pixel to be loaded into the output register
   fp_t    u_q, u_d;
   fp_t    v_q, v_d;
   logic [H_BITS-1:0]    h_q, h_d;
   logic [V_BITS-1:0]    vc_q, vc_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic   valid_q, valid_d;
   vec3_t  origin_q, origin_d;
   vec3_t  dir_q, dir_d;
   logic [ADDR_BITS-1:0] out_addr_q, out_addr_d;
   logic [H_BITS-1:0]    out_h_q, out_h_d;
   logic [V_BITS-1:0]    out_v_q, out_v_d;
   logic   busy_q, busy_d;
   logic   done_q, done_d;

   vec3_t  next_dir;
   logic   accept;
   logic   last_out;

   // direction of the pending pixel: fwd + u*R + v*up, with R = (fwd.z, 0, -fwd.x)
   always_comb begin
      next_dir   = '0;
      next_dir.x = fp_add(cam_fwd_q.x, fp_mul(u_q, cam_fwd_q.z));
      next_dir.y = fp_add(cam_fwd_q.y, v_q);
      next_dir.z = fp_sub(cam_fwd_q.z, fp_mul(u_q, cam_fwd_q.x));
   end

   // next-state and datapath control
   always_comb begin
      state_d    = state_q;
      cam_pos_d  = cam_pos_q;
      cam_fwd_d  = cam_fwd_q;
      u_d        = u_q;
      v_d        = v_q;
      h_d        = h_q;
      vc_d       = vc_q;
      addr_d     = addr_q;
      valid_d    = valid_q;
      origin_d   = origin_q;
      dir_d      = dir_q;
      out_addr_d = out_addr_q;
      out_h_d    = out_h_q;
      out_v_d    = out_v_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      accept     = valid_q && ray_ready_in;
      last_out   = (out_h_q == H_LAST) && (out_v_q == V_LAST);

      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               state_d = S_LOAD;
               busy_d  = 1'b1;
            end
         end
         S_LOAD: begin
            cam_pos_d = pos_in;
            cam_fwd_d = dir_in;
            u_d       = U_START;
            v_d       = V_START;
            h_d       = '0;
            vc_d      = '0;
            addr_d    = '0;
            state_d   = S_EMIT;
         end
         S_EMIT: begin
            if (accept && last_out) begin
               valid_d = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (!valid_q || accept) begin
               // output register empty or drained: move the pending pixel out
               valid_d    = 1'b1;
               origin_d   = cam_pos_q;
               dir_d      = next_dir;
               out_addr_d = addr_q;
               out_h_d    = h_q;
               out_v_d    = vc_q;
               addr_d     = addr_q + ADDR_BITS'(1);
               if (h_q == H_LAST) begin
                  h_d  = '0;
                  u_d  = U_START;
                  vc_d = vc_q + V_BITS'(1);
                  v_d  = fp_sub(v_q, PIXEL_STEP);
               end else begin
                  h_d = h_q + H_BITS'(1);
                  u_d = fp_add(u_q, PIXEL_STEP);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= S_IDLE;
         cam_pos_q  <= '0;
         cam_fwd_q  <= '0;
         u_q        <= FP_ZERO;
         v_q        <= FP_ZERO;
         h_q        <= '0;
         vc_q       <= '0;
         addr_q     <= '0;
         valid_q    <= 1'b0;
         origin_q   <= '0;
         dir_q      <= '0;
         out_addr_q <= '0;
         out_h_q    <= '0;
         out_v_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cam_pos_q  <= cam_pos_d;
         cam_fwd_q  <= cam_fwd_d;
         u_q        <= u_d;
         v_q        <= v_d;
         h_q        <= h_d;
         vc_q       <= vc_d;
         addr_q     <= addr_d;
         valid_q    <= valid_d;
         origin_q   <= origin_d;
         dir_q      <= dir_d;
         out_addr_q <= out_addr_d;
         out_h_q    <= out_h_d;
         out_v_q    <= out_v_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign ray_valid_out  = valid_q;
   assign ray_origin_out = origin_q;
   assign ray_dir_out    = dir_q;
   assign ray_addr_out   = out_addr_q;
   assign hcount_out     = out_h_q;
   assign vcount_out     = out_v_q;
   assign busy_out       = busy_q;
   assign frame_done_out = done_q;

endmodule

// File: tb/tb_camera_ray_generator.sv
// tb/tb_camera_ray_generator.sv - self-checking bench for camera_ray_generator

module tb_camera_ray_generator;
   import camera_ray_pkg::*;

   localparam int  W    = 4;
   localparam int  H    = 2;
   localparam int  HB   = 2;
   localparam int  VB   = 1;
   localparam int  AB   = 3;
   localparam fp_t STEP = 32'sh0000_8000;
   localparam fp_t ONE  = 32'sh0001_0000;
   localparam fp_t HALF = 32'sh0000_8000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_in = 1'b0;
   vec3_t         pos_in = '0;
   vec3_t         dir_in = '0;
   logic          ray_valid_out;
   logic          ray_ready_in = 1'b0;
   vec3_t         ray_origin_out;
   vec3_t         ray_dir_out;
   logic [AB-1:0] ray_addr_out;
   logic [HB-1:0] hcount_out;
   logic [VB-1:0] vcount_out;
   logic          busy_out;
   logic          frame_done_out;

   int total = 0;
   int bad   = 0;

   vec3_t         cap_dir  [2][W*H];
   vec3_t         cap_org  [2][W*H];
   int            cap_addr [2][W*H];
   int            cap_h    [2][W*H];
   int            cap_v    [2][W*H];

   typedef struct {
      int  slot;
      int  idx;
      int  addr;
      int  h;
      int  v;
      fp_t dx, dy, dz;
   } tv_t;
   tv_t tbl [5];

   camera_ray_generator #(
      .DISPLAY_WIDTH (W),
      .DISPLAY_HEIGHT(H),
      .H_BITS        (HB),
      .V_BITS        (VB),
      .ADDR_BITS     (AB),
      .PIXEL_STEP    (STEP)
   ) dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .start_in      (start_in),
      .pos_in        (pos_in),
      .dir_in        (dir_in),
      .ray_valid_out (ray_valid_out),
      .ray_ready_in  (ray_ready_in),
      .ray_origin_out(ray_origin_out),
      .ray_dir_out   (ray_dir_out),
      .ray_addr_out  (ray_addr_out),
      .hcount_out    (hcount_out),
      .vcount_out    (vcount_out),
      .busy_out      (busy_out),
      .frame_done_out(frame_done_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference model: ray for linear pixel index k, computed directly from (h, row)
   function automatic fp_t m_sat(input longint x);
      if (x > 64'sd2147483647)  return 32'sh7FFF_FFFF;
      if (x < -64'sd2147483648) return 32'sh8000_0000;
      return fp_t'(x);
   endfunction

   function automatic fp_t m_mul(input fp_t a, input fp_t b);
      longint p;
      p = longint'(a) * longint'(b);
      return m_sat(p >>> 16);
   endfunction

   function automatic vec3_t m_ray(input vec3_t f, input int k);
      int    h, r;
      fp_t   u, v;
      vec3_t d;
      h   = k % W;
      r   = k / W;
      u   = fp_t'(-(W / 2) * STEP + h * STEP);
      v   = fp_t'((H / 2) * STEP - r * STEP);
      d.x = m_sat(longint'(f.x) + longint'(m_mul(u, f.z)));
      d.y = m_sat(longint'(f.y) + longint'(v));
      d.z = m_sat(longint'(f.z) - longint'(m_mul(u, f.x)));
      return d;
   endfunction

   function automatic vec3_t rnd_vec();
      vec3_t r;
      r.x = fp_t'($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000;
      r.y = fp_t'($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000;
      r.z = fp_t'($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000;
      return r;
   endfunction

   function automatic vec3_t mk(input fp_t x, input fp_t y, input fp_t z);
      vec3_t r;
      r.x = x;
      r.y = y;
      r.z = z;
      return r;
   endfunction

   // Runs one frame from the current negedge; returns at the negedge where frame_done is seen.
   task automatic run_frame(input vec3_t pos, input vec3_t dir, input int ready_pct,
                            input bit disturb, input bit hold, input int slot);
      int    k = 0;
      int    ndone = 0;
      int    first_valid = -1;
      bit    prev_stall = 1'b0;
      bit    rdy;
      vec3_t p_dir, p_org, e_dir;
      int    p_addr;
      pos_in   = pos;
      dir_in   = dir;
      start_in = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (i == 1) begin
            if (!hold) start_in = 1'b0;
            check("busy_in_load", busy_out, 1'b1);
         end
         if (disturb && i == 6) begin
            pos_in   = rnd_vec();
            dir_in   = rnd_vec();
            start_in = 1'b1;
         end
         if (disturb && i == 8) start_in = 1'b0;
         if (frame_done_out) begin
            ndone++;
            check("done_count", 96'(k), 96'(W * H));
            check("done_busy", busy_out, 1'b0);
            check("done_valid", ray_valid_out, 1'b0);
            break;
         end
         if (i >= 2 && first_valid >= 0) check("busy_held", busy_out, 1'b1);
         if (ray_valid_out) begin
            if (first_valid < 0) begin
               first_valid = i;
               check("first_latency", 96'(i), 96'd3);
            end
            if (prev_stall) begin
               check("stall_dir", ray_dir_out, p_dir);
               check("stall_org", ray_origin_out, p_org);
               check("stall_addr", 96'(ray_addr_out), 96'(p_addr));
            end
            rdy = ($urandom_range(0, 99) < ready_pct);
            ray_ready_in = rdy;
            if (rdy) begin
               e_dir = m_ray(dir, k);
               check("ray_addr", 96'(ray_addr_out), 96'(k));
               check("ray_h", 96'(hcount_out), 96'(k % W));
               check("ray_v", 96'(vcount_out), 96'(k / W));
               check("ray_origin", ray_origin_out, pos);
               check("ray_dir", ray_dir_out, e_dir);
               if (slot >= 0 && k < W * H) begin
                  cap_dir[slot][k]  = ray_dir_out;
                  cap_org[slot][k]  = ray_origin_out;
                  cap_addr[slot][k] = int'(ray_addr_out);
                  cap_h[slot][k]    = int'(hcount_out);
                  cap_v[slot][k]    = int'(vcount_out);
               end
               k++;
            end
            prev_stall = !rdy;
            p_dir  = ray_dir_out;
            p_org  = ray_origin_out;
            p_addr = int'(ray_addr_out);
         end else begin
            prev_stall   = 1'b0;
            ray_ready_in = ($urandom_range(0, 99) < ready_pct);
         end
      end
      check("frame_done_seen", 96'(ndone), 96'd1);
   endtask

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_no_done", frame_done_out, 1'b0);
         check("idle_no_valid", ray_valid_out, 1'b0);
      end
   endtask

   initial begin
      vec3_t p1, d1, dx;
      int    guard;
      p1 = mk(32'sh0, ONE, -32'sh0001_8000);
      d1 = mk(32'sh0, 32'sh0, ONE);
      dx = mk(ONE, 32'sh0, 32'sh0);

      tbl[0] = '{0, 0, 0, 0, 0, -ONE, HALF, ONE};
      tbl[1] = '{0, 3, 3, 3, 0, HALF, HALF, ONE};
      tbl[2] = '{0, 4, 4, 0, 1, -ONE, 32'sh0, ONE};
      tbl[3] = '{0, 7, 7, 3, 1, HALF, 32'sh0, ONE};
      tbl[4] = '{1, 0, 0, 0, 0, ONE, HALF, ONE};

      // reset state
      #1;
      check("rst_valid", ray_valid_out, 1'b0);
      check("rst_busy", busy_out, 1'b0);
      check("rst_done", frame_done_out, 1'b0);
      check("rst_addr", 96'(ray_addr_out), 96'd0);
      check("rst_hv", 96'({hcount_out, vcount_out}), 96'd0);
      check("rst_origin", ray_origin_out, 96'd0);
      check("rst_dir", ray_dir_out, 96'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // directed frames captured for the vector table
      run_frame(p1, d1, 100, 1'b0, 1'b0, 0);
      idle_check(3);
      run_frame(p1, dx, 100, 1'b0, 1'b0, 1);
      idle_check(2);

      for (int i = 0; i < 5; i++) begin
         check("tbl_addr", 96'(cap_addr[tbl[i].slot][tbl[i].idx]), 96'(tbl[i].addr));
         check("tbl_h", 96'(cap_h[tbl[i].slot][tbl[i].idx]), 96'(tbl[i].h));
         check("tbl_v", 96'(cap_v[tbl[i].slot][tbl[i].idx]), 96'(tbl[i].v));
         check("tbl_dir", cap_dir[tbl[i].slot][tbl[i].idx], mk(tbl[i].dx, tbl[i].dy, tbl[i].dz));
      end
      check("tbl_origin", cap_org[0][0], p1);

      // random pose with random backpressure
      for (int f = 0; f < 3; f++) begin
         run_frame(rnd_vec(), rnd_vec(), 50, 1'b0, 1'b0, -1);
         idle_check(2);
      end

      // mid-frame pose change and start request
      run_frame(rnd_vec(), rnd_vec(), 50, 1'b1, 1'b0, -1);
      idle_check(3);

      // start held high: back-to-back frames
      run_frame(rnd_vec(), rnd_vec(), 100, 1'b0, 1'b1, -1);
      run_frame(rnd_vec(), rnd_vec(), 70, 1'b0, 1'b1, -1);
      start_in = 1'b0;
      idle_check(3);

      // asynchronous reset at pixel 5
      pos_in       = p1;
      dir_in       = d1;
      start_in     = 1'b1;
      ray_ready_in = 1'b1;
      guard        = 0;
      @(negedge clk);
      start_in = 1'b0;
      while (!(ray_valid_out && ray_addr_out == AB'(5)) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("reach_pixel5", 96'(ray_addr_out), 96'd5);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", ray_valid_out, 1'b0);
      check("arst_busy", busy_out, 1'b0);
      check("arst_addr", 96'(ray_addr_out), 96'd0);
      check("arst_hv", 96'({hcount_out, vcount_out}), 96'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("arst_no_done", frame_done_out, 1'b0);
      end
      rst = 1'b0;
      idle_check(2);
      run_frame(rnd_vec(), rnd_vec(), 60, 1'b0, 1'b0, -1);
      idle_check(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/camera_ray_generator.md
Name: camera_ray_generator

Overview:
- Sits directly downstream of the user-control stage.
- At frame start it snapshots camera position and forward direction, then walks the display raster in row-major order.
- For each pixel it emits one primary ray (origin, unnormalised direction, framebuffer address) to the ray-marcher over a valid/ready handshake.
- Per-pixel offsets use incremental fixed-point accumulation, not per-pixel multiplies of counters.

Parameters:
- DISPLAY_WIDTH, `DISPLAY_WIDTH: pixels per row.
- DISPLAY_HEIGHT, `DISPLAY_HEIGHT: rows per frame.
- H_BITS, `H_BITS: width of hcount_out.
- V_BITS, `V_BITS: width of vcount_out.
- ADDR_BITS, `ADDR_BITS: width of ray_addr_out.
- PIXEL_STEP, fp encoding of 2/DISPLAY_WIDTH (elaboration-time constant): screen-plane distance between adjacent pixels.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: asynchronous, active-high reset.
- start_in, input, 1: request a new frame; sampled only in IDLE.
- pos_in, input, vec3: camera position from user control.
- dir_in, input, vec3: camera forward direction (y component expected 0) from user control.
- ray_valid_out, output, 1: ray outputs hold a valid ray.
- ray_ready_in, input, 1: marcher accepts the ray this cycle.
- ray_origin_out, output, vec3: ray origin (the frame's snapshotted position).
- ray_dir_out, output, vec3: unnormalised ray direction.
- ray_addr_out, output, ADDR_BITS: framebuffer address, vcount*DISPLAY_WIDTH + hcount.
- hcount_out, output, H_BITS: pixel column.
- vcount_out, output, V_BITS: pixel row.
- busy_out, output, 1: high from the LOAD state until frame_done_out.
- frame_done_out, output, 1: one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset (async, rst_in high): state IDLE; ray_valid_out=0; busy_out=0; frame_done_out=0; hcount_out, vcount_out, ray_addr_out = 0; ray_origin_out, ray_dir_out = FP_ZERO. Reset mid-frame abandons the frame; no frame_done_out pulse.
- States:
  - IDLE: when start_in=1, go to LOAD.
  - LOAD (1 cycle):
    - cam_pos<=pos_in; cam_fwd<=dir_in.
    - u<=U_START, where U_START = -(DISPLAY_WIDTH/2)*PIXEL_STEP.
    - v<=V_START, where V_START = (DISPLAY_HEIGHT/2)*PIXEL_STEP.
    - Counters <= 0. Then go to EMIT.
  - EMIT: ray outputs registered from current cam/u/v/counters; ray_valid_out=1.
- Latency: first ray_valid_out is 2 cycles after the start_in sample in IDLE. busy_out rises in LOAD.
- Direction math uses right vector R = (fwd.z, 0, -fwd.x) and up vector = (0,1,0):
  - ray_dir.x = fwd.x + fp_mul(u, fwd.z)
  - ray_dir.y = fwd.y + v
  - ray_dir.z = fwd.z - fp_mul(u, fwd.x)
  - All arithmetic uses fp_add/fp_sub/fp_mul saturation/wrap rules. No normalisation in this block.
- Handshake:
  - Outputs hold stable while ray_valid_out && !ray_ready_in.
  - On ray_valid_out && ray_ready_in, advance one pixel; the next ray is valid the following cycle, giving 1 ray/cycle throughput under continuous ready.
- Advance rules:
  - hcount +1, u += PIXEL_STEP, addr +1.
  - At hcount = DISPLAY_WIDTH-1: hcount<=0, u<=U_START, vcount +1, v -= PIXEL_STEP.
- Frame end:
  - Acceptance of pixel (DISPLAY_WIDTH-1, DISPLAY_HEIGHT-1) sets ray_valid_out<=0 and frame_done_out<=1 for exactly one cycle, and returns to IDLE (busy_out<=0 same edge).
  - If start_in is high in that IDLE cycle, the next frame loads immediately. No pixel is emitted twice or skipped.
- pos_in/dir_in changes during LOAD+1..frame end do not affect the current frame.
- start_in outside IDLE is ignored.
- ray_addr_out counts linearly 0..W*H-1; no wrap within a frame.

Test Plan (bench uses DISPLAY_WIDTH=4, DISPLAY_HEIGHT=2, PIXEL_STEP=FP_ONE/2, so U_START=-1.0 and V_START=0.5):
- Reset release, start_in pulse, pos_in=(0,1,-1.5), dir_in=(0,0,1), ready=1 -> valid 2 cycles later, then 8 consecutive rays:
  - pixel 0: addr 0, dir (-1.0,0.5,1.0), origin (0,1,-1.5).
  - pixel 3: addr 3, dir (0.5,0.5,1.0).
  - pixel 4: addr 4, (h,v)=(0,1), dir (-1.0,0,1.0).
  - pixel 7: dir (0.5,0,1.0).
  - frame_done_out pulses once, 1 cycle after pixel 7 accepted.
- dir_in=(1,0,0), pixel (0,0) -> ray_dir=(1.0,0.5,1.0).
- Random ray_ready_in backpressure (~50%) -> outputs stable while stalled; exactly 8 unique addrs 0..7 in order; one frame_done_out.
- Change pos_in/dir_in mid-frame and assert start_in mid-frame -> current frame rays unchanged; no restart; busy_out high throughout.
- start_in held high continuously -> back-to-back frames, IDLE lasts 1 cycle, addr restarts at 0.
- Assert rst_in asynchronously at pixel 5 -> ray_valid_out, busy_out, and counters are 0 immediately (before next edge); no frame_done_out; next start produces a full frame from addr 0.
